// File: rtl/lsu_bus_adapter_pkg.sv
// ---------------------------------------------------------------------------
// lsu_bus_adapter_pkg: shared size/state encodings and lane helpers | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_bus_adapter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = off[0];
      SIZE_WORD: is_misaligned = (off != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SIZE_BYTE: lane_strobe = 4'b0001 << off;
      SIZE_HALF: lane_strobe = 4'b0011 << off;
      SIZE_WORD: lane_strobe = 4'b1111;
      default:   lane_strobe = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] replicate_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SIZE_BYTE: replicate_data = {4{data[7:0]}};
      SIZE_HALF: replicate_data = {2{data[15:0]}};
      default:   replicate_data = data;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_bus_adapter_if.sv
// ---------------------------------------------------------------------------
// lsu_bus_adapter_if: word-wide memory bus between LSU adapter and memory | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface lsu_bus_adapter_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_bus_adapter_load_extender.sv
// ---------------------------------------------------------------------------
// load_extender: selects the load lane from a bus word and sign/zero extends | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_extender
  import lsu_bus_adapter_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:   data = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_bus_adapter.sv
// ---------------------------------------------------------------------------
// lsu_bus_adapter: turns one LSU load/store request into a timed bus access | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_bus_adapter
  import lsu_bus_adapter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      we,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  input  logic [1:0]                data_size,
  input  logic                      data_unsigned,
  output logic                      busy,
  output logic                      done,
  output logic [31:0]               rdata,
  output logic                      misaligned,
  output logic                      timeout,
  lsu_bus_adapter_if.master         bus
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] load_data;
  logic        start_mis;

  assign start_mis     = is_misaligned(data_size, addr[1:0]);
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  load_extender u_load_extender (
    .word        (bus.mem_rdata),
    .lane        (lane_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .data        (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      lane_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            timeout    <= 1'b0;
            misaligned <= start_mis;
            wait_cnt   <= '0;
            lane_q     <= addr[1:0];
            size_q     <= data_size;
            unsigned_q <= data_unsigned;
            we_q       <= we;
            addr_q     <= {addr[31:2], 2'b00};
            wdata_q    <= replicate_data(data_size, wdata);
            wstrb_q    <= (we && !start_mis) ? lane_strobe(data_size, addr[1:0]) : 4'b0000;
            // Misaligned accesses never touch the bus and finish next cycle.
            if (start_mis) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_BUS;
              req_q <= 1'b1;
            end
          end
        end
        ST_BUS: begin
          if (bus.mem_ack) begin
            req_q <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
            if (!we_q) begin
              rdata <= load_data;
            end
          end else if (wait_cnt == TIMEOUT_LAST) begin
            req_q   <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            state   <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_bus_adapter.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_adapter: directed and random load/store checks against a model | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lsu_bus_adapter;
  import lsu_bus_adapter_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  data_size = '0;
  logic        data_unsigned = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        misaligned;
  logic        timeout;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rdata = '0;

  lsu_bus_adapter_if bus ();

  lsu_bus_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .data_size     (data_size),
    .data_unsigned (data_unsigned),
    .busy          (busy),
    .done          (done),
    .rdata         (rdata),
    .misaligned    (misaligned),
    .timeout       (timeout),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: plain arithmetic on the access rules
  function automatic bit f_mis(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] f_strb(input logic [1:0] sz, input logic [31:0] a);
    int off = int'(a % 4);
    if (sz == 2'd0) return 32'(1 << off);
    if (sz == 2'd1) return 32'(3 << off);
    return 32'd15;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] f_load(input logic [31:0] rw, input logic [31:0] a,
                                         input logic [1:0] sz, input logic u);
    logic [31:0] v;
    v = rw >> ((a % 4) * 8);
    if (sz == 2'd0) begin
      v = v & 32'hFF;
      if (!u && v >= 32'd128) v = v - 32'd256;
    end else if (sz == 2'd1) begin
      v = v & 32'hFFFF;
      if (!u && v >= 32'd32768) v = v - 32'd65536;
    end else begin
      v = rw;
    end
    return v;
  endfunction

  // d = wait cycles before ack; d >= TO means the memory never answers in time
  task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic u, input int d,
                       input logic [31:0] rw, input bit poke);
    bit mis;
    bit timed;
    int total;
    mis   = f_mis(sz, a);
    timed = !mis && (d >= TO);
    total = mis ? 1 : (timed ? TO + 1 : d + 2);
    @(negedge clk);
    start = 1'b1; we = w; addr = a; wdata = wd; data_size = sz; data_unsigned = u;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      check("busy", busy, 1);
      check("done", done, (c == total));
      check("mem_req", bus.mem_req, (!mis && c < total));
      if (!mis && c < total) begin
        check("mem_addr", bus.mem_addr, a & ~32'd3);
        check("mem_we", bus.mem_we, w);
        check("mem_wstrb", bus.mem_wstrb, w ? f_strb(sz, a) : 32'd0);
        if (w) check("mem_wdata", bus.mem_wdata, f_wdata(sz, wd));
      end
      if (c == total) begin
        if (!w && !mis && !timed) exp_rdata = f_load(rw, a, sz, u);
        check("misaligned", misaligned, mis);
        check("timeout", timeout, timed);
        check("rdata", rdata, exp_rdata);
      end
      start = poke && (c < total) && ($urandom % 3 == 0);
      if (start) begin
        we = 1'($urandom); addr = $urandom; wdata = $urandom; data_size = 2'($urandom);
      end
      bus.mem_ack   = mis ? 1'($urandom) : (c - 1 == d);
      bus.mem_rdata = (!mis && c - 1 == d) ? rw : $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    bus.mem_ack = 1'($urandom);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_req", bus.mem_req, 0);
    check("rdata_hold", rdata, exp_rdata);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("idle_done2", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=0x%08h exp=0x%08h", n_checks, 0);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_wstrb", bus.mem_wstrb, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_rdata", rdata, 0);
    rst_n = 1'b1;

    do_op(1'b1, 32'h0000_1003, 32'h0000_00A5, SIZE_BYTE, 1'b0, 0, 32'h0, 1'b0);
    do_op(1'b0, 32'h0000_2002, 32'h0, SIZE_BYTE, 1'b0, 0, 32'h1280_FF00, 1'b0);
    check("lb", rdata, 32'hFFFF_FF80);
    do_op(1'b0, 32'h0000_2002, 32'h0, SIZE_BYTE, 1'b1, 1, 32'h1280_FF00, 1'b0);
    check("lbu", rdata, 32'h0000_0080);
    do_op(1'b0, 32'h0000_2002, 32'h0, SIZE_HALF, 1'b0, 3, 32'h8001_0000, 1'b0);
    check("lh", rdata, 32'hFFFF_8001);
    do_op(1'b0, 32'h0000_2002, 32'h0, SIZE_HALF, 1'b1, 3, 32'h8001_0000, 1'b0);
    check("lhu", rdata, 32'h0000_8001);
    do_op(1'b0, 32'h0000_3002, 32'h0, SIZE_WORD, 1'b0, 0, 32'hDEAD_BEEF, 1'b0);
    check("lw_mis_rdata", rdata, 32'h0000_8001);
    do_op(1'b0, 32'h0000_4000, 32'h0, SIZE_WORD, 1'b0, 99, 32'h1234_5678, 1'b1);
    check("to_rdata", rdata, 32'h0000_8001);

    // Reset in the middle of a bus transfer
    @(negedge clk);
    start = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h5555_AAAA; data_size = SIZE_WORD;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_rst_req", bus.mem_req, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_req", bus.mem_req, 0);
    check("async_busy", busy, 0);
    check("async_rdata", rdata, 0);
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
    end
    do_op(1'b1, 32'h0000_0010, 32'hCAFE_F00D, SIZE_WORD, 1'b0, 1, 32'h0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom % 4 != 0) begin
        if (sz == SIZE_WORD) a = a & ~32'd3;
        else if (sz == SIZE_HALF) a = a & ~32'd1;
      end
      do_op(1'($urandom), a, $urandom, sz, 1'($urandom), int'($urandom % 7), $urandom, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_bus_adapter.md
LSU_BUS_ADAPTER -- requirements
Module: lsu_bus_adapter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, max cycles mem_req waits for mem_ack before aborting (legal range 1..65535).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle request from control FSM (memory read/write state).
REQ-005 we  in  1  1 = store, 0 = load.
REQ-006 addr  in  32  byte address of access.
REQ-007 wdata  in  32  store data, right-justified.
REQ-008 data_size  in  2  shared SIZE_BYTE=00, SIZE_HALF=01, SIZE_WORD=10; 11 is illegal.
REQ-009 data_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-010 busy  out  1  high from cycle after accepted start until done cycle inclusive.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 rdata  out  32  formatted load result, held until next accepted load completes.
REQ-013 misaligned  out  1  error flag, valid with done.
REQ-014 timeout  out  1  error flag, valid with done.
REQ-015 mem_req / mem_we  out  1 / 1  bus request and write enable.
REQ-016 mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-017 mem_wdata  out  32  store data replicated across lanes (byte x4, half x2, word).
REQ-018 mem_wstrb  out  4  byte-lane strobes; 0000 on loads.
REQ-019 mem_ack / mem_rdata  in  1 / 32  bus acknowledge and read word, sampled same cycle.

Function
REQ-020 States: IDLE, BUS, DONE; all bus outputs registered, captured at accepted start.
REQ-021 start accepted only in IDLE; start while busy is ignored with no side effects.
REQ-022 Misaligned = (half and addr[0]) or (word and addr[1:0]!=0) or data_size=11; IDLE->DONE, mem_req never asserted, misaligned=1.
REQ-023 Aligned start: IDLE->BUS; mem_req=1 from cycle after start; mem_we, mem_addr, mem_wdata, mem_wstrb stable while mem_req=1.
REQ-024 Strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-025 mem_ack sampled high in BUS: mem_req drops next cycle, BUS->DONE; loads capture rdata that edge.
REQ-026 Load formatting: select lane by addr[1:0], extend per data_unsigned (word ignores data_unsigned).
REQ-027 Zero-wait latency: start at T, mem_req at T+1, ack at T+1, done at T+2; done at ack cycle +1 generally.
REQ-028 Timeout counter cleared on BUS entry; if TIMEOUT_CYCLES cycles elapse in BUS without ack, BUS->DONE, timeout=1, mem_req drops, rdata unchanged.
REQ-029 DONE lasts exactly one cycle, then IDLE; error flags cleared at next accepted start.
REQ-030 mem_ack outside BUS is ignored.

Reset
REQ-031 On reset low, immediately: state IDLE, mem_req=0, mem_we=0, mem_wstrb=0000, busy=0, done=0, misaligned=0, timeout=0, rdata=0, mem_addr=0, mem_wdata=0, counter=0.
REQ-032 Reset mid-BUS aborts transfer with no done pulse; first start after release treated as fresh.

Structure
REQ-033 SIZE_* encodings and state encodings live in the shared constants file; no local redefinition.
REQ-034 Load lane-select/extension is sub-module load_extender (combinational); FSM, counter, registers in lsu_bus_adapter.

Verification
REQ-035 sb addr=0x00001003 wdata=0x000000A5, ack at once -> mem_addr=0x00001000, wstrb=1000, mem_wdata=0xA5A5A5A5, done 2 cycles after start.
REQ-036 lb addr=0x00002002, mem_rdata=0x1280FF00 -> rdata=0xFFFFFF80; same as lbu -> 0x00000080.
REQ-037 lh addr=0x00002002, mem_rdata=0x80010000 -> rdata=0xFFFF8001; lhu -> 0x00008001; ack after 3 waits -> done 1 cycle after ack.
REQ-038 lw addr=0x00003002 -> misaligned=1, done 1 cycle after start, mem_req never high, rdata unchanged.
REQ-039 TIMEOUT_CYCLES=4, no ack -> mem_req high 4 cycles, then low, timeout=1 with done; start while busy ignored.
REQ-040 reset low during BUS -> mem_req, busy low without clock edge; no done; next sw addr=0x10 completes normally.
